// File: rtl/receiver.sv
`default_nettype none
// ============================================================================
//  Module      : receiver
//  Description : Serial-to-parallel UART receiver. Frame = start(0), 8 data
//                bits LSB first, even parity, two stop bits (12 bit-times).
//                Delivers bytes on a held valid/acknowledge interface with
//                parity, framing and overrun flags.
//  Revision    : 1.0 - initial release
// ============================================================================
module receiver #(
    parameter int unsigned ClocksPerBit = 1
) (
    input  logic       Clock,
    input  logic       Reset,
    input  logic       RxIn,
    input  logic       DataAck,
    output logic [7:0] DataOut,
    output logic       DataValid,
    output logic       ParityError,
    output logic       FrameError,
    output logic       OverrunError
);

    // Last count value of one bit-time, and the half-bit offset of the
    // sample point measured from the first low cycle seen in IDLE.
    localparam logic [15:0] c_last_tick  = 16'(ClocksPerBit - 32'd1);
    localparam logic [15:0] c_half       = 16'((ClocksPerBit - 32'd1) / 32'd2);
    localparam logic [15:0] c_start_tick = c_half - 16'd1;
    localparam bit          c_half_zero  = (c_half == 16'd0);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP1  = 3'd4,
        ST_STOP2  = 3'd5,
        ST_BREAK  = 3'd6
    } state_t;

    state_t      r_state;
    state_t      w_state_next;
    logic        r_sync1;
    logic        r_sync2;
    logic        w_rx;
    logic [15:0] r_count;
    logic [15:0] w_count_next;
    logic [3:0]  r_bit_idx;
    logic [3:0]  w_idx_next;
    logic        w_bit_tick;
    logic        w_deliver;
    logic [7:0]  r_shift;
    logic        r_perr_pend;
    logic        r_ferr_pend;
    logic        w_frame_ferr;
    logic [7:0]  r_data_out;
    logic        r_valid;
    logic        r_perr;
    logic        r_ferr;
    logic        r_ovr;

    assign w_rx         = r_sync2;
    assign w_bit_tick   = (r_count == c_last_tick);
    assign w_frame_ferr = r_ferr_pend | ~w_rx;

    assign DataOut      = r_data_out;
    assign DataValid    = r_valid;
    assign ParityError  = r_perr;
    assign FrameError   = r_ferr;
    assign OverrunError = r_ovr;

    // Two-flop synchroniser for the asynchronous line; idles high.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
        end else begin
            r_sync1 <= RxIn;
            r_sync2 <= r_sync1;
        end
    end

    // Next-state, counter and delivery-strobe decode.
    always_comb begin
        w_state_next = r_state;
        w_count_next = r_count + 16'd1;
        w_idx_next   = r_bit_idx;
        w_deliver    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_count_next = 16'd0;
                // With a zero half-bit offset the start sample coincides
                // with detection, so it is already known to be low.
                if (!w_rx) begin
                    w_state_next = c_half_zero ? ST_DATA : ST_START;
                end
            end
            ST_START: begin
                if (r_count == c_start_tick) begin
                    w_state_next = w_rx ? ST_IDLE : ST_DATA;
                end
            end
            ST_DATA: begin
                if (w_bit_tick) begin
                    w_count_next = 16'd0;
                    w_idx_next   = r_bit_idx + 4'd1;
                    if (r_bit_idx == 4'd7) begin
                        w_state_next = ST_PARITY;
                    end
                end
            end
            ST_PARITY: begin
                if (w_bit_tick) begin
                    w_state_next = ST_STOP1;
                end
            end
            ST_STOP1: begin
                if (w_bit_tick) begin
                    w_state_next = ST_STOP2;
                end
            end
            ST_STOP2: begin
                if (w_bit_tick) begin
                    w_deliver    = 1'b1;
                    w_state_next = w_rx ? ST_IDLE : ST_BREAK;
                end
            end
            ST_BREAK: begin
                w_count_next = 16'd0;
                if (w_rx) begin
                    w_state_next = ST_IDLE;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
        if (w_state_next != r_state) begin
            w_count_next = 16'd0;
            w_idx_next   = 4'd0;
        end
    end

    // State register, bit-time counter and bit index.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            r_state   <= ST_IDLE;
            r_count   <= 16'd0;
            r_bit_idx <= 4'd0;
        end else begin
            r_state   <= w_state_next;
            r_count   <= w_count_next;
            r_bit_idx <= w_idx_next;
        end
    end

    // Frame assembly: data shift register and pending error flags.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            r_shift     <= 8'h00;
            r_perr_pend <= 1'b0;
            r_ferr_pend <= 1'b0;
        end else begin
            if (r_state == ST_IDLE) begin
                r_ferr_pend <= 1'b0;
            end
            if (r_state == ST_DATA && w_bit_tick) begin
                r_shift <= {w_rx, r_shift[7:1]};
            end
            if (r_state == ST_PARITY && w_bit_tick) begin
                r_perr_pend <= w_rx ^ (^r_shift);
            end
            if (r_state == ST_STOP1 && w_bit_tick && !w_rx) begin
                r_ferr_pend <= 1'b1;
            end
        end
    end

    // Consumer interface: deliver, drop on overrun, or acknowledge.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            r_data_out <= 8'h00;
            r_valid    <= 1'b0;
            r_perr     <= 1'b0;
            r_ferr     <= 1'b0;
            r_ovr      <= 1'b0;
        end else if (w_deliver) begin
            if (!r_valid || DataAck) begin
                r_data_out <= r_shift;
                r_perr     <= r_perr_pend;
                r_ferr     <= w_frame_ferr;
                r_valid    <= 1'b1;
                if (DataAck) begin
                    r_ovr <= 1'b0;
                end
            end else begin
                r_ovr <= 1'b1;
            end
        end else if (DataAck) begin
            r_valid <= 1'b0;
            r_ovr   <= 1'b0;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_receiver.sv
`default_nettype none
// ============================================================================
//  Module      : tb_receiver
//  Description : Self-checking bench for receiver. Two instances: one at
//                one clock per bit, one at sixteen clocks per bit. Expected
//                outputs come from a frame-level reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_receiver;

    localparam int c_cpb0 = 1;
    localparam int c_cpb1 = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       rx0, rx1, ack0, ack1;
    logic [7:0] dout0, dout1;
    logic       dv0, dv1, pe0, pe1, fe0, fe1, ov0, ov1;
    logic [11:0] obs [2];

    int checks   = 0;
    int failures = 0;

    // Reference model of the consumer-visible state, per instance.
    logic [7:0] m_data  [2];
    logic       m_valid [2];
    logic       m_perr  [2];
    logic       m_ferr  [2];
    logic       m_ovr   [2];

    receiver #(.ClocksPerBit(c_cpb0)) u_dut0 (
        .Clock(clk), .Reset(rst), .RxIn(rx0), .DataAck(ack0),
        .DataOut(dout0), .DataValid(dv0), .ParityError(pe0),
        .FrameError(fe0), .OverrunError(ov0)
    );

    receiver #(.ClocksPerBit(c_cpb1)) u_dut1 (
        .Clock(clk), .Reset(rst), .RxIn(rx1), .DataAck(ack1),
        .DataOut(dout1), .DataValid(dv1), .ParityError(pe1),
        .FrameError(fe1), .OverrunError(ov1)
    );

    always_comb begin
        obs[0] = {dout0, dv0, pe0, fe0, ov0};
        obs[1] = {dout1, dv1, pe1, fe1, ov1};
    end

    function automatic int cpb(input int s);
        return (s == 0) ? c_cpb0 : c_cpb1;
    endfunction

    function automatic logic [11:0] expv(input int s);
        return {m_data[s], m_valid[s], m_perr[s], m_ferr[s], m_ovr[s]};
    endfunction

    function automatic void mdl_reset();
        for (int s = 0; s < 2; s++) begin
            m_data[s] = 8'h00; m_valid[s] = 1'b0; m_perr[s] = 1'b0;
            m_ferr[s] = 1'b0;  m_ovr[s]   = 1'b0;
        end
    endfunction

    // A completed frame as seen by the consumer.
    function automatic void mdl_deliver(input int s, input logic [7:0] d,
                                        input bit pflip, input bit s1,
                                        input bit s2, input bit ack);
        if (!m_valid[s] || ack) begin
            m_data[s]  = d;
            m_perr[s]  = pflip;
            m_ferr[s]  = !s1 || !s2;
            m_valid[s] = 1'b1;
            if (ack) m_ovr[s] = 1'b0;
        end else begin
            m_ovr[s] = 1'b1;
        end
    endfunction

    function automatic void mdl_ack(input int s);
        m_valid[s] = 1'b0;
        m_ovr[s]   = 1'b0;
    endfunction

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic set_line(input int s, input logic v);
        if (s == 0) rx0 = v; else rx1 = v;
    endtask

    task automatic set_ack(input int s, input logic v);
        if (s == 0) ack0 = v; else ack1 = v;
    endtask

    task automatic do_ack(input int s);
        set_ack(s, 1'b1);
        tick(1);
        set_ack(s, 1'b0);
        mdl_ack(s);
    endtask

    // Drives one frame; the line is left at the stop2 level.
    task automatic send_frame(input int s, input logic [7:0] d, input bit pflip,
                              input bit s1, input bit s2);
        logic [11:0] bits;
        bits = {s2, s1, (^d) ^ pflip, d, 1'b0};
        for (int i = 0; i < 12; i++) begin
            set_line(s, bits[i]);
            tick(cpb(s));
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; rx0 = 1'b1; rx1 = 1'b1; ack0 = 1'b0; ack1 = 1'b0;
        tick(3);
        mdl_reset();
        for (int s = 0; s < 2; s++) begin
            checks++;
            if (obs[s] !== 12'h000) begin
                failures++;
                $display("FAIL reset_state[%0d]: got %h expected %h", s, obs[s], 12'h000);
            end
        end
        rst = 1'b0;
        tick(5);
        checks++;
        if (obs[0] !== expv(0)) begin
            failures++;
            $display("FAIL reset_idle: got %h expected %h", obs[0], expv(0));
        end
    endtask

    task automatic test_clean();
        logic [11:0] bits;
        int rise;
        bits = 12'b110_1010_0101_0;
        rise = -1;
        for (int c = 0; c < 20; c++) begin
            set_line(0, (c < 12) ? bits[c] : 1'b1);
            if (rise < 0 && dv0) rise = c;
            tick(1);
        end
        checks++;
        if (rise != 14) begin
            failures++;
            $display("FAIL clean_latency: got %0d expected %0d", rise, 14);
        end
        mdl_deliver(0, 8'hA5, 1'b0, 1'b1, 1'b1, 1'b0);
        checks++;
        if (obs[0] !== expv(0)) begin
            failures++;
            $display("FAIL clean_frame: got %h expected %h", obs[0], expv(0));
        end
        do_ack(0);
        checks++;
        if (obs[0] !== expv(0)) begin
            failures++;
            $display("FAIL clean_ack: got %h expected %h", obs[0], expv(0));
        end
    endtask

    task automatic test_parity();
        send_frame(0, 8'h01, 1'b1, 1'b1, 1'b1);
        set_line(0, 1'b1);
        tick(3);
        mdl_deliver(0, 8'h01, 1'b1, 1'b1, 1'b1, 1'b0);
        checks++;
        if (obs[0] !== expv(0)) begin
            failures++;
            $display("FAIL parity_err: got %h expected %h", obs[0], expv(0));
        end
        do_ack(0);
        send_frame(0, 8'h3C, 1'b0, 1'b1, 1'b1);
        set_line(0, 1'b1);
        tick(3);
        mdl_deliver(0, 8'h3C, 1'b0, 1'b1, 1'b1, 1'b0);
        checks++;
        if (obs[0] !== expv(0)) begin
            failures++;
            $display("FAIL parity_clear: got %h expected %h", obs[0], expv(0));
        end
        do_ack(0);
    endtask

    task automatic test_break();
        send_frame(0, 8'h55, 1'b0, 1'b1, 1'b0);
        set_line(0, 1'b0);
        tick(20);
        mdl_deliver(0, 8'h55, 1'b0, 1'b1, 1'b0, 1'b0);
        checks++;
        if (obs[0] !== expv(0)) begin
            failures++;
            $display("FAIL break_frame_err: got %h expected %h", obs[0], expv(0));
        end
        do_ack(0);
        tick(20);
        checks++;
        if (obs[0] !== expv(0)) begin
            failures++;
            $display("FAIL break_no_delivery: got %h expected %h", obs[0], expv(0));
        end
        set_line(0, 1'b1);
        tick(4);
        send_frame(0, 8'h12, 1'b0, 1'b1, 1'b1);
        set_line(0, 1'b1);
        tick(3);
        mdl_deliver(0, 8'h12, 1'b0, 1'b1, 1'b1, 1'b0);
        checks++;
        if (obs[0] !== expv(0)) begin
            failures++;
            $display("FAIL break_recover: got %h expected %h", obs[0], expv(0));
        end
        do_ack(0);
    endtask

    task automatic test_false_start();
        set_line(1, 1'b0);
        tick(3);
        set_line(1, 1'b1);
        tick(40);
        checks++;
        if (obs[1] !== expv(1)) begin
            failures++;
            $display("FAIL false_start: got %h expected %h", obs[1], expv(1));
        end
        send_frame(1, 8'hF0, 1'b0, 1'b1, 1'b1);
        set_line(1, 1'b1);
        tick(3);
        mdl_deliver(1, 8'hF0, 1'b0, 1'b1, 1'b1, 1'b0);
        checks++;
        if (obs[1] !== expv(1)) begin
            failures++;
            $display("FAIL false_start_recover: got %h expected %h", obs[1], expv(1));
        end
        do_ack(1);
    endtask

    task automatic test_back_to_back();
        send_frame(0, 8'h11, 1'b0, 1'b1, 1'b1);
        send_frame(0, 8'h22, 1'b0, 1'b1, 1'b1);
        set_line(0, 1'b1);
        tick(3);
        mdl_deliver(0, 8'h11, 1'b0, 1'b1, 1'b1, 1'b0);
        mdl_deliver(0, 8'h22, 1'b0, 1'b1, 1'b1, 1'b0);
        checks++;
        if (obs[0] !== expv(0)) begin
            failures++;
            $display("FAIL overrun: got %h expected %h", obs[0], expv(0));
        end
        do_ack(0);
        checks++;
        if (obs[0] !== expv(0)) begin
            failures++;
            $display("FAIL overrun_ack: got %h expected %h", obs[0], expv(0));
        end
        send_frame(0, 8'h11, 1'b0, 1'b1, 1'b1);
        send_frame(0, 8'h22, 1'b0, 1'b1, 1'b1);
        set_line(0, 1'b1);
        // The 0x22 stop2 sample falls one cycle after the frame ends.
        tick(1);
        set_ack(0, 1'b1);
        tick(1);
        set_ack(0, 1'b0);
        mdl_deliver(0, 8'h11, 1'b0, 1'b1, 1'b1, 1'b0);
        mdl_deliver(0, 8'h22, 1'b0, 1'b1, 1'b1, 1'b1);
        tick(2);
        checks++;
        if (obs[0] !== expv(0)) begin
            failures++;
            $display("FAIL ack_at_delivery: got %h expected %h", obs[0], expv(0));
        end
    endtask

    task automatic test_reset_midframe();
        logic [11:0] bits;
        bits = {1'b1, 1'b1, ^8'h99, 8'h99, 1'b0};
        for (int i = 0; i < 6; i++) begin
            set_line(0, bits[i]);
            tick(1);
        end
        rst = 1'b1;
        set_line(0, 1'b1);
        tick(1);
        mdl_reset();
        for (int s = 0; s < 2; s++) begin
            checks++;
            if (obs[s] !== expv(s)) begin
                failures++;
                $display("FAIL midframe_reset[%0d]: got %h expected %h", s, obs[s], expv(s));
            end
        end
        rst = 1'b0;
        tick(20);
        checks++;
        if (obs[0] !== expv(0)) begin
            failures++;
            $display("FAIL midframe_discard: got %h expected %h", obs[0], expv(0));
        end
        send_frame(0, 8'h7E, 1'b0, 1'b1, 1'b1);
        set_line(0, 1'b1);
        tick(3);
        mdl_deliver(0, 8'h7E, 1'b0, 1'b1, 1'b1, 1'b0);
        checks++;
        if (obs[0] !== expv(0)) begin
            failures++;
            $display("FAIL midframe_recover: got %h expected %h", obs[0], expv(0));
        end
        do_ack(0);
    endtask

    task automatic test_random(input int s, input int n);
        logic [7:0] d;
        bit pflip, s1, s2;
        for (int f = 0; f < n; f++) begin
            tick($urandom_range(0, 3));
            if ($urandom_range(0, 1) == 1) begin
                do_ack(s);
                checks++;
                if (obs[s] !== expv(s)) begin
                    failures++;
                    $display("FAIL random_ack[%0d.%0d]: got %h expected %h", s, f, obs[s], expv(s));
                end
            end
            d     = 8'($urandom);
            pflip = ($urandom_range(0, 3) == 0);
            s1    = ($urandom_range(0, 3) != 0);
            s2    = ($urandom_range(0, 3) != 0);
            send_frame(s, d, pflip, s1, s2);
            set_line(s, 1'b1);
            tick(3);
            mdl_deliver(s, d, pflip, s1, s2, 1'b0);
            checks++;
            if (obs[s] !== expv(s)) begin
                failures++;
                $display("FAIL random_frame[%0d.%0d]: got %h expected %h", s, f, obs[s], expv(s));
            end
        end
    endtask

    initial begin
        test_reset();
        test_clean();
        test_parity();
        test_break();
        test_false_start();
        test_back_to_back();
        test_reset_midframe();
        test_random(0, 40);
        test_random(1, 8);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/receiver.md
# receiver

Serial-to-parallel UART receiver, the receive end of the uart_app link. It deserialises frames of one start bit (0), 8 data bits LSB first, one even-parity bit (parity bit = XOR of the data bits) and two stop bits (1), for 12 bit-times per frame. It delivers each byte on a held valid/acknowledge interface with parity, framing and overrun flags. It sits between the serial line pin and the application-side byte consumer.

## Interface
- ClocksPerBit, 1, clock cycles per bit-time, legal range 1..65535. The value 1 matches the transmitter's one-bit-per-clock line rate.
- Clock  input  1  sole clock; all logic on posedge.
- Reset  input  1  synchronous, active-high reset.
- RxIn  input  1  asynchronous serial line; idle high.
- DataAck  input  1  consumer acknowledge; clears DataValid and OverrunError.
- DataOut  output  8  last delivered byte.
- DataValid  output  1  high while DataOut holds an unacknowledged byte.
- ParityError  output  1  parity mismatch on the last delivered frame.
- FrameError  output  1  stop1 or stop2 sampled 0 on the last delivered frame.
- OverrunError  output  1  a frame completed while DataValid=1 and no DataAck was given.

## Operation
- **Synchroniser.** RxIn passes through a 2-flop synchroniser, producing RxSync. All decisions use RxSync only.
- **Reset values.** Reset=1 at a posedge gives: DataOut=0x00, DataValid=0, ParityError=0, FrameError=0, OverrunError=0, state=IDLE, synchroniser flops=1, counters=0. Reset overrides all other inputs, including mid-frame; a partial frame is discarded and never delivered.
- **Sample timing.** H = (ClocksPerBit-1)/2 (integer division). Let t0 be the first cycle in IDLE with RxSync=0.
  - The start bit is sampled at t0+H.
  - Bit k is sampled at t0+H+(k+1)*ClocksPerBit, where k=0..7 is data, k=8 is parity, k=9 is stop1 and k=10 is stop2.
- **State machine:**
  - IDLE → START on RxSync=0.
  - START: at the sample point, if RxSync=1 it is a false start → IDLE, no flags, no delivery. If RxSync=0 → DATA.
  - DATA: shift each sample into bit index 0..7 (LSB first). After bit 7 → PARITY.
  - PARITY: store the mismatch as (sample XOR ^data) → STOP1.
  - STOP1: a 0 sample sets the pending frame error. Always → STOP2.
  - STOP2: a 0 sample sets the pending frame error. Then deliver the frame:
    - → IDLE if the stop2 sample is 1;
    - → BREAK if the stop2 sample is 0.
  - BREAK: wait for RxSync=1 → IDLE. No start is detected while in BREAK.
- **Delivery** (the cycle after the stop2 sample):
  - If DataValid=0, or DataAck=1 in that same cycle: load DataOut, set ParityError and FrameError from this frame, and set DataValid=1.
  - Otherwise (DataValid=1 and DataAck=0): DataOut, ParityError and FrameError keep their old values, OverrunError is set to 1, and the new byte is dropped.
- **Acknowledge.** DataAck=1 with no delivery in that cycle clears DataValid and OverrunError. DataAck while DataValid=0 has no effect.
- **Error-flag behaviour.** ParityError and FrameError change only at delivery. A frame with errors is still delivered.
- **Counters.** The bit-time counter is 16 bits and the bit index is 4 bits. Both reset to 0 on every state transition.

## Timing
- RxIn first low at cycle T → t0 = T+2.
- DataValid rises at T+2+H+11*ClocksPerBit+1, which is T+14 for ClocksPerBit=1.
- Back-to-back frames: IDLE is entered in the cycle after the stop2 sample, so a start bit is detected with zero idle bit-times between frames.
- DataValid, DataOut and the error flags are registered outputs and change only on a posedge.
- Throughput: one byte per 12 bit-times. The consumer must acknowledge within 12*ClocksPerBit cycles to avoid overrun.

## Test plan
- **Clean frame.** ClocksPerBit=1, line 0,1,0,1,0,0,1,0,1,0,1,1 (byte 0xA5, parity 0). Required: DataOut=0xA5, DataValid=1 at T+14, ParityError=0, FrameError=0. After DataAck=1 for one cycle, DataValid=0.
- **Parity error.** Byte 0x01 sent with parity bit 0. Required: DataOut=0x01, ParityError=1, FrameError=0. The next clean frame 0x3C clears ParityError.
- **Framing error and break.** Byte 0x55 with stop2=0, then the line held low for 20 cycles. Required: FrameError=1 and DataOut=0x55, with no further delivery until the line returns high. A subsequent 0x12 frame is received cleanly.
- **False start.** ClocksPerBit=16, low glitch of 3 cycles (H=7). Required: no DataValid and no flags. A following 0xF0 frame is received correctly with ClocksPerBit=16.
- **Overrun and simultaneous events.**
  - Frames 0x11 then 0x22 back-to-back, no DataAck. Required: DataOut=0x11 and OverrunError=1.
  - Repeat with DataAck=1 in the 0x22 delivery cycle. Required: DataOut=0x22, DataValid=1, OverrunError=0.
- **Reset mid-frame.** Assert Reset after data bit 4 of 0x99. Required: all outputs return to their reset values the next cycle, no delivery occurs, and a following 0x7E frame is received cleanly.
